// File: rtl/aes_model_pack.sv
// Shared types and constants for the AES key/sync loader slice.
package aes_model_pack;

   localparam int unsigned CFG_WIDTH = 32;
   localparam int unsigned CFG_WORDS = 8;

   typedef logic [127:0] data_block;

   typedef enum logic {
      ASM_COLLECT,
      ASM_DRAIN
   } asm_state_t;

   typedef enum logic {
      OUT_EMPTY,
      OUT_HOLD
   } out_state_t;

endpackage

// File: rtl/aes_key_sync_loader_if.sv
// Bus interfaces: Avalon-ST style config stream and valid/ready key/sync output.
interface avalon_st_if;
   import aes_model_pack::*;

   logic [CFG_WIDTH-1:0] data;
   logic                 valid;
   logic                 rdy;
   logic                 sop;
   logic                 eop;
   logic [1:0]           empty;

   modport master (output data, valid, sop, eop, empty, input rdy);
   modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

interface dvr_key_if;
   import aes_model_pack::*;

   data_block key;
   data_block sync;
   logic      valid;
   logic      rdy;

   modport master (output key, sync, valid, input rdy);
   modport slave  (input key, sync, valid, output rdy);
endinterface

// File: rtl/aes_cfg_assembler.sv
// Assembles config beats into a staged key/sync pair and flags malformed packets.
module aes_cfg_assembler
   import aes_model_pack::*;
#(
   parameter int unsigned CFG_WIDTH = 32,
   parameter int unsigned CFG_WORDS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 beat_vld,
   input  logic [CFG_WIDTH-1:0] beat_data,
   input  logic                 beat_sop,
   input  logic                 beat_eop,
   output data_block            stage_key,
   output data_block            stage_sync,
   output logic                 commit,
   output logic                 err
);

   localparam int unsigned KW    = CFG_WORDS / 2;
   localparam int unsigned CNT_W = $clog2(CFG_WORDS);

   asm_state_t       state, state_nxt;
   logic [CNT_W-1:0] word_cnt, cnt_nxt;
   logic [CNT_W-1:0] word_idx;
   logic             at_last;
   logic             collect_beat;
   logic             err_set;
   data_block        key_q, sync_q;

   // A sop beat always lands in word 0, whatever the count was.
   assign word_idx = beat_sop ? '0 : word_cnt;
   assign at_last  = (word_idx == CNT_W'(CFG_WORDS - 1));

   // State register and word counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ASM_COLLECT;
         word_cnt <= '0;
      end else begin
         state    <= state_nxt;
         word_cnt <= cnt_nxt;
      end
   end

   // Next-state and next-count decode on each accepted beat.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = word_cnt;
      if (beat_vld) begin
         unique case (state)
            ASM_COLLECT: begin
               if (beat_eop) begin
                  cnt_nxt = '0;
               end else if (at_last) begin
                  state_nxt = ASM_DRAIN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = word_idx + 1'b1;
               end
            end
            ASM_DRAIN: begin
               if (beat_eop) begin
                  state_nxt = ASM_COLLECT;
                  cnt_nxt   = '0;
               end
            end
            default: begin
               state_nxt = ASM_COLLECT;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Output decode: commit on a well-formed last beat, error on any framing fault.
   always_comb begin
      collect_beat = beat_vld && (state == ASM_COLLECT);
      commit       = collect_beat && beat_eop && at_last;
      err_set      = collect_beat &&
                     ((beat_sop && (word_cnt != '0)) ||
                      (beat_eop && !at_last) ||
                      (!beat_eop && at_last));
   end

   // Error pulse register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err <= 1'b0;
      else      err <= err_set;
   end

   // Staging registers, MSB word first; only COLLECT beats are stored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_q  <= '0;
         sync_q <= '0;
      end else if (collect_beat) begin
         for (int unsigned i = 0; i < KW; i++) begin
            if (word_idx == CNT_W'(i))
               key_q[(KW-i)*CFG_WIDTH-1 -: CFG_WIDTH] <= beat_data;
            if (word_idx == CNT_W'(KW + i))
               sync_q[(KW-i)*CFG_WIDTH-1 -: CFG_WIDTH] <= beat_data;
         end
      end
   end

   // The final sync word arrives with the commit beat, so it bypasses staging.
   assign stage_key  = key_q;
   assign stage_sync = commit ? {sync_q[127:CFG_WIDTH], beat_data} : sync_q;

endmodule

// File: rtl/aes_key_sync_loader.sv
// Loads key/sync pairs from config packets and offers them with auto-incrementing sync.
module aes_key_sync_loader
   import aes_model_pack::*;
#(
   parameter int unsigned CFG_WIDTH = 32,
   parameter int unsigned CFG_WORDS = 8
) (
   input  logic         clk,
   input  logic         rst,
   avalon_st_if.slave   cfg_in,
   dvr_key_if.master    key_and_sync,
   input  logic         key_clear,
   output logic         cfg_err,
   output logic         sync_wrap
);

   out_state_t   state, state_nxt;
   logic         out_valid;
   logic         hs;
   logic         cfg_beat;
   logic         commit;
   data_block    stage_key, stage_sync;
   data_block    key_q, sync_q;
   logic [128:0] sync_sum;
   logic         wrap_q;
   logic         cfg_empty_unused;

   // Every config beat is a full word, so empty carries no information.
   assign cfg_empty_unused = ^cfg_in.empty;

   // Ready follows reset directly: low while held in reset, high every cycle after.
   assign cfg_in.rdy = rst;
   assign cfg_beat   = cfg_in.valid & cfg_in.rdy;

   aes_cfg_assembler #(
      .CFG_WIDTH (CFG_WIDTH),
      .CFG_WORDS (CFG_WORDS)
   ) u_asm (
      .clk        (clk),
      .rst        (rst),
      .beat_vld   (cfg_beat),
      .beat_data  (cfg_in.data),
      .beat_sop   (cfg_in.sop),
      .beat_eop   (cfg_in.eop),
      .stage_key  (stage_key),
      .stage_sync (stage_sync),
      .commit     (commit),
      .err        (cfg_err)
   );

   assign hs       = out_valid & key_and_sync.rdy;
   assign sync_sum = {1'b0, sync_q} + 129'd1;

   // Output FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= OUT_EMPTY;
      else      state <= state_nxt;
   end

   // Output FSM next state: clear beats commit.
   always_comb begin
      state_nxt = state;
      if (key_clear)   state_nxt = OUT_EMPTY;
      else if (commit) state_nxt = OUT_HOLD;
   end

   // Output FSM decode: valid comes from state only, never from rdy.
   always_comb begin
      out_valid = (state == OUT_HOLD);
   end

   // Held pair: clear over commit over increment; a same-cycle handshake
   // consumes the old pair, so a fresh commit is presented unincremented.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_q  <= '0;
         sync_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         if (key_clear) begin
            key_q  <= '0;
            sync_q <= '0;
         end else if (commit) begin
            key_q  <= stage_key;
            sync_q <= stage_sync;
         end else if (hs) begin
            sync_q <= sync_sum[127:0];
            wrap_q <= sync_sum[128];
         end
      end
   end

   assign key_and_sync.key   = key_q;
   assign key_and_sync.sync  = sync_q;
   assign key_and_sync.valid = out_valid;
   assign sync_wrap          = wrap_q;

endmodule

// File: tb/tb_aes_key_sync_loader.sv
// Directed bench for aes_key_sync_loader with hand-computed expectations.
module tb_aes_key_sync_loader;

   logic clk;
   logic rst;
   logic key_clear;
   logic cfg_err;
   logic sync_wrap;
   int   total;
   int   bad;

   avalon_st_if cfg_bus ();
   dvr_key_if   ks_bus ();

   aes_key_sync_loader #(
      .CFG_WIDTH (32),
      .CFG_WORDS (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_in       (cfg_bus),
      .key_and_sync (ks_bus),
      .key_clear    (key_clear),
      .cfg_err      (cfg_err),
      .sync_wrap    (sync_wrap)
   );

   localparam logic [127:0] K   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] S   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] S1  = 128'h00112233445566778899aabbccddef00;
   localparam logic [127:0] S2P = 128'h00112233445566778899aabbccddef01;
   localparam logic [127:0] KX  = 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;
   localparam logic [127:0] SX  = 128'h77777777777777777777777777777777;
   localparam logic [127:0] K2  = 128'hdeadbeefcafebabe0123456789abcdef;
   localparam logic [127:0] S2  = 128'hffffffffffffffffffffffffffffffff;
   localparam logic [127:0] K3  = 128'ha0a1a2a3b0b1b2b3c0c1c2c3d0d1d2d3;
   localparam logic [127:0] S3  = 128'h00000000000000000000000000000010;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [127:0] k, input logic [127:0] s, input int i);
      logic [127:0] blk;
      blk = (i < 4) ? k : s;
      return blk[127 - 32*(i % 4) -: 32];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] d, input logic sop, input logic eop);
      cfg_bus.valid = 1'b1;
      cfg_bus.data  = d;
      cfg_bus.sop   = sop;
      cfg_bus.eop   = eop;
   endtask

   task automatic idle();
      cfg_bus.valid = 1'b0;
      cfg_bus.data  = '0;
      cfg_bus.sop   = 1'b0;
      cfg_bus.eop   = 1'b0;
   endtask

   task automatic beat(input logic [31:0] d, input logic sop, input logic eop);
      drive(d, sop, eop);
      tick();
      idle();
   endtask

   task automatic send_pkt(input logic [127:0] k, input logic [127:0] s);
      for (int i = 0; i < 8; i++) beat(word_of(k, s, i), i == 0, i == 7);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      total         = 0;
      bad           = 0;
      rst           = 1'b0;
      key_clear     = 1'b0;
      ks_bus.rdy    = 1'b0;
      cfg_bus.empty = '0;
      idle();
      tick();
      tick();

      chk("rst_valid", ks_bus.valid, 0);
      chk("rst_key", ks_bus.key, 0);
      chk("rst_sync", ks_bus.sync, 0);
      chk("rst_cfg_rdy", cfg_bus.rdy, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_sync_wrap", sync_wrap, 0);

      rst = 1'b1;
      tick();
      chk("cfg_rdy_after_rst", cfg_bus.rdy, 1);

      // Short packet: eop at word 4.
      for (int i = 0; i < 5; i++) beat(word_of(KX, SX, i), i == 0, i == 4);
      chk("short_err", cfg_err, 1);
      chk("short_valid", ks_bus.valid, 0);
      tick();
      chk("short_err_pulse", cfg_err, 0);

      // Good packet with rdy held high.
      ks_bus.rdy = 1'b1;
      send_pkt(K, S);
      chk("good_valid", ks_bus.valid, 1);
      chk("good_key", ks_bus.key, K);
      chk("good_sync", ks_bus.sync, S);
      tick();
      chk("inc1_sync", ks_bus.sync, S1);
      chk("inc1_key", ks_bus.key, K);
      tick();
      chk("inc2_sync", ks_bus.sync, S2P);
      ks_bus.rdy = 1'b0;
      tick();
      chk("stall_sync", ks_bus.sync, S2P);
      chk("stall_valid", ks_bus.valid, 1);

      // Overlong packet: no eop at word 7, then two drained beats.
      for (int i = 0; i < 8; i++) beat(word_of(KX, SX, i), i == 0, 1'b0);
      chk("long_err", cfg_err, 1);
      beat(32'h12345678, 1'b0, 1'b0);
      chk("drain_err_clear", cfg_err, 0);
      beat(32'h9abcdef0, 1'b0, 1'b1);
      chk("drain_key", ks_bus.key, K);
      chk("drain_sync", ks_bus.sync, S2P);
      send_pkt(K2, S2);
      chk("after_drain_key", ks_bus.key, K2);
      chk("after_drain_sync", ks_bus.sync, S2);
      chk("after_drain_err", cfg_err, 0);

      // Sync wrap on one handshake.
      ks_bus.rdy = 1'b1;
      tick();
      ks_bus.rdy = 1'b0;
      chk("wrap_sync", ks_bus.sync, 0);
      chk("wrap_key", ks_bus.key, K2);
      chk("wrap_pulse", sync_wrap, 1);
      tick();
      chk("wrap_pulse_end", sync_wrap, 0);
      chk("wrap_sync_hold", ks_bus.sync, 0);

      // Commit and handshake in the same cycle.
      for (int i = 0; i < 7; i++) beat(word_of(K3, S3, i), i == 0, 1'b0);
      drive(word_of(K3, S3, 7), 1'b0, 1'b1);
      ks_bus.rdy = 1'b1;
      #1;
      chk("coincide_old_key", ks_bus.key, K2);
      chk("coincide_old_sync", ks_bus.sync, 0);
      tick();
      idle();
      ks_bus.rdy = 1'b0;
      chk("coincide_new_key", ks_bus.key, K3);
      chk("coincide_new_sync", ks_bus.sync, S3);
      tick();
      chk("coincide_sync_hold", ks_bus.sync, S3);

      // sop restarting a partial packet.
      beat(word_of(KX, SX, 0), 1'b1, 1'b0);
      beat(word_of(KX, SX, 1), 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         beat(word_of(K, S, i), i == 0, i == 7);
         if (i == 0) chk("restart_err", cfg_err, 1);
      end
      chk("restart_key", ks_bus.key, K);
      chk("restart_sync", ks_bus.sync, S);

      // key_clear coinciding with a commit and a handshake.
      for (int i = 0; i < 7; i++) beat(word_of(K2, S2, i), i == 0, 1'b0);
      drive(word_of(K2, S2, 7), 1'b0, 1'b1);
      key_clear  = 1'b1;
      ks_bus.rdy = 1'b1;
      tick();
      idle();
      key_clear  = 1'b0;
      ks_bus.rdy = 1'b0;
      chk("clr_commit_valid", ks_bus.valid, 0);
      chk("clr_commit_key", ks_bus.key, 0);
      chk("clr_commit_sync", ks_bus.sync, 0);
      chk("clr_commit_wrap", sync_wrap, 0);

      // Reset in the middle of a packet.
      send_pkt(K3, S3);
      chk("pre_rst_valid", ks_bus.valid, 1);
      for (int i = 0; i < 3; i++) beat(word_of(K, S, i), i == 0, 1'b0);
      drive(word_of(K, S, 3), 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      chk("midrst_valid", ks_bus.valid, 0);
      chk("midrst_key", ks_bus.key, 0);
      chk("midrst_cfg_rdy", cfg_bus.rdy, 0);
      tick();
      idle();
      rst = 1'b1;
      for (int i = 4; i < 8; i++) beat(word_of(K, S, i), 1'b0, i == 7);
      chk("postrst_valid", ks_bus.valid, 0);
      chk("postrst_key", ks_bus.key, 0);
      chk("postrst_err", cfg_err, 1);

      // key_clear while holding.
      send_pkt(K, S);
      chk("hold_valid", ks_bus.valid, 1);
      key_clear = 1'b1;
      tick();
      key_clear = 1'b0;
      chk("clear_valid", ks_bus.valid, 0);
      chk("clear_key", ks_bus.key, 0);
      chk("clear_sync", ks_bus.sync, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aes_key_sync_loader.md
AES_KEY_SYNC_LOADER -- requirements
Module: aes_key_sync_loader

Interface
REQ-001 Parameter CFG_WIDTH, default 32, width of one config beat; fixed at 32, no other value supported.
REQ-002 Parameter CFG_WORDS, default 8, beats per config packet: 4 key words, then 4 sync words.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 cfg_in  avalon_st_if.slave  data 32, valid, rdy, sop, eop, empty  config packet input.
REQ-006 key_and_sync  dvr_key_if.master  key 128, sync 128, valid, rdy  key/sync pair offered to the encryptor.
REQ-007 key_clear  in  1  synchronous pulse; discards the held pair.
REQ-008 cfg_err  out  1  one-cycle pulse on a malformed config packet.
REQ-009 sync_wrap  out  1  one-cycle pulse when the auto-increment wraps sync from all-ones to zero.

Function
REQ-010 A cfg beat SHALL be accepted when cfg_in.valid & cfg_in.rdy; cfg_in.rdy SHALL be 1 in every cycle after reset release.
REQ-011 Beat k (0..3) SHALL go to staging key bits [127-32k -: 32]; beat k (4..7) SHALL go to staging sync bits [127-32(k-4) -: 32] (MSB first).
REQ-012 Assembler FSM states: COLLECT (word_cnt 0..7) and DRAIN.
REQ-013 In COLLECT, a beat with sop SHALL restart at word 0, discarding any partial packet, and SHALL raise cfg_err if word_cnt was not 0.
REQ-014 A beat with eop at word 7 SHALL commit the staging key/sync to the output registers; the new pair SHALL appear with key_and_sync.valid=1 on the next cycle (1-cycle latency).
REQ-015 An eop before word 7 SHALL discard staging, pulse cfg_err, and return to word 0 in COLLECT.
REQ-016 Word 7 without eop SHALL pulse cfg_err and enter DRAIN; DRAIN SHALL discard beats until an eop beat, then return to COLLECT at word 0.
REQ-017 The output pair SHALL change only on commit, auto-increment, or clear; it never carries a partially updated value.
REQ-018 Output FSM states: EMPTY (valid=0) and HOLD (valid=1). EMPTY->HOLD on commit. HOLD->EMPTY on key_clear.
REQ-019 In HOLD, each handshake (valid & rdy) SHALL present key unchanged and sync+1 mod 2^128 on the next cycle; valid SHALL stay 1.
REQ-020 If sync is all-ones at the handshake, sync SHALL become 0 and sync_wrap SHALL pulse on the next cycle.
REQ-021 If a handshake and a commit occur in the same cycle, the handshake SHALL consume the old pair and the committed pair SHALL be presented unincremented.
REQ-022 key_clear SHALL override a commit and a handshake in the same cycle: valid=0, key=0, sync=0 next cycle; staging and assembler state SHALL be unaffected.
REQ-023 key_and_sync.valid SHALL NOT depend combinationally on key_and_sync.rdy, and key/sync SHALL be stable while valid=1 and rdy=0.

Reset
REQ-024 While rst=0: key_and_sync.valid=0, key=0, sync=0, cfg_in.rdy=0, cfg_err=0, sync_wrap=0, assembler in COLLECT at word 0, output FSM in EMPTY.
REQ-025 Reset asserted mid-packet or mid-handshake SHALL discard all staged and held data; no commit SHALL occur from a packet that began before reset.

Structure
REQ-026 The data_block typedef (128 bits), CFG_WORDS, and the two FSM state enums SHALL reside in aes_model_pack.
REQ-027 Config beat assembly (REQ-011..016) SHALL be a sub-module named aes_cfg_assembler, with outputs staged key, staged sync, commit pulse, and err pulse.
REQ-028 The output FSM, increment logic, and clear logic SHALL reside in aes_key_sync_loader; sync+1 SHALL be a single 128-bit adder.

Verification
REQ-029 8-beat packet key 000102..0f, sync 00112233..ff, rdy=1 held -> valid rises the cycle after eop with that pair; sync then increments by 1 on every subsequent cycle.
REQ-030 Sync ffff..ff loaded, one handshake -> sync=0000..00, key unchanged, sync_wrap high for exactly one cycle.
REQ-031 5-beat packet ending in eop -> cfg_err one pulse, valid stays 0; then a good packet -> commit as in REQ-029.
REQ-032 10-beat packet with no eop at beat 8 -> cfg_err at beat 8, beats 9-10 ignored, held pair unchanged; next good packet commits.
REQ-033 Commit eop and handshake in the same cycle -> the encryptor receives the old pair; the next cycle shows the new pair with its sync not incremented.
REQ-034 rst pulse low at beat 3 of a packet, then the remaining beats 4-7 with eop -> no commit and valid=0; key_clear while in HOLD -> valid=0 the next cycle.
